// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x3 matrix keypad column scanner with row synchroniser,
// per-scan key decode, debounce FSM and rollover blocking.
// Optional macro KEYPAD_SYMBOL_EN: '*' reports 4'd11 and '#' reports 4'd12;
// without it both symbols are ignored and key never exceeds 4'd10.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_strobe
);

  localparam int         SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] NOKEY = 4'd10;
  localparam logic [3:0] DS    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASE} state_e;

  // Key code at (row r, column c); NOKEY for the unused index slots.
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'd1;  4'h1: k = 4'd2; 4'h2: k = 4'd3;
      4'h4: k = 4'd4;  4'h5: k = 4'd5; 4'h6: k = 4'd6;
      4'h8: k = 4'd7;  4'h9: k = 4'd8; 4'hA: k = 4'd9;
      4'hC: k = 4'd11; 4'hD: k = 4'd0; 4'hE: k = 4'd12;
      default: k = NOKEY;
    endcase
    return k;
  endfunction

  // Whether a decoded code takes part in scan results at all.
  function automatic logic key_ok(input logic [3:0] k);
`ifdef KEYPAD_SYMBOL_EN
    return (k <= 4'd9) || (k == 4'd11) || (k == 4'd12);
`else
    return k <= 4'd9;
`endif
  endfunction

  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [2:0]    col_q, col_d;
  logic [3:0]    row_m_q, row_s_q;
  logic [1:0]    acc_n_q, acc_n_d;     // keys seen this scan, saturates at 2
  logic [3:0]    acc_code_q, acc_code_d;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d, cand_q, cand_d, key_q, key_d;
  logic          strobe_q, strobe_d;

  logic          sample, scan_end;
  logic [1:0]    seen_n;
  logic [3:0]    seen_code;
  logic          res_none, res_key;

  assign sample   = (slot_q == SW'(SCAN_DIV - 1));
  assign scan_end = sample && (cidx_q == 2'd2);

  // Fold the current column's rows into the running scan accumulator.
  always_comb begin
    seen_n    = acc_n_q;
    seen_code = acc_code_q;
    for (int r = 0; r < 4; r++) begin
      if (!row_s_q[r] && key_ok(keymap(2'(r), cidx_q))) begin
        if (seen_n != 2'd2) seen_n = seen_n + 2'd1;
        seen_code = keymap(2'(r), cidx_q);
      end
    end
  end

  assign res_none = (seen_n == 2'd0);
  assign res_key  = (seen_n == 2'd1);

  // Slot counter, column rotation and accumulator update.
  always_comb begin
    slot_d     = sample ? '0 : slot_q + 1'b1;
    cidx_d     = cidx_q;
    col_d      = col_q;
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      cidx_d = (cidx_q == 2'd2) ? 2'd0 : cidx_q + 2'd1;
      col_d  = {col_q[1:0], col_q[2]};
      if (scan_end) begin
        acc_n_d    = 2'd0;
        acc_code_d = NOKEY;
      end else begin
        acc_n_d    = seen_n;
        acc_code_d = seen_code;
      end
    end
  end

  // Debounce FSM; only scan-end cycles move it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (res_key) begin
            cand_d = seen_code;
            cnt_d  = 4'd1;
            if (DS == 4'd1) begin
              state_d  = PRESSED;
              key_d    = seen_code;
              strobe_d = 1'b1;
            end else begin
              state_d = CAND;
            end
          end
        end
        CAND: begin
          if (res_key && seen_code == cand_q) begin
            if (cnt_q + 4'd1 >= DS) begin
              cnt_d    = DS;
              state_d  = PRESSED;
              key_d    = cand_q;
              strobe_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (res_key) begin
            cand_d = seen_code;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (!(res_key && seen_code == cand_q)) begin
            if (res_none && DS == 4'd1) begin
              // A single quiet scan is already a full release.
              state_d = IDLE;
              cnt_d   = 4'd0;
              key_d   = NOKEY;
            end else begin
              state_d = RELEASE;
              cnt_d   = res_none ? 4'd1 : 4'd0;
            end
          end
        end
        default: begin // RELEASE
          if (res_none) begin
            if (cnt_q + 4'd1 >= DS) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              key_d   = NOKEY;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (res_key && seen_code == cand_q) begin
            state_d = PRESSED;
          end else begin
            cnt_d = 4'd0;
          end
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_q     <= '0;
      cidx_q     <= 2'd0;
      col_q      <= 3'b110;
      row_m_q    <= 4'b1111;
      row_s_q    <= 4'b1111;
      acc_n_q    <= 2'd0;
      acc_code_q <= NOKEY;
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      cand_q     <= NOKEY;
      key_q      <= NOKEY;
      strobe_q   <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      cidx_q     <= cidx_d;
      col_q      <= col_d;
      row_m_q    <= row;
      row_s_q    <= row_m_q;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      key_q      <= key_d;
      strobe_q   <= strobe_d;
    end
  end

  assign col        = col_q;
  assign key        = key_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving rows from the pressed-key set and
// the column drive, with a scan-level reference of press/release debouncing.
module tb_keypad_scanner;
  localparam int SD    = 4;
  localparam int DS    = 3;
  localparam int SCANP = 3 * SD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  key;
  logic        key_strobe;

  // Pressed keys, index = row*3 + column.
  logic [11:0] pset = '0;

  // Reference state.
  int          n = 0;
  int          held = 10;
  int          run_val = 10;
  int          run_len = 0;
  logic        exp_strobe = 1'b0;
  logic [2:0]  exp_col = 3'b110;
  logic        chk_en = 1'b0;

  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clock(clock), .reset(reset), .row(row), .col(col),
    .key(key), .key_strobe(key_strobe)
  );

  // Physical keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pset[r*3+c] && col[c] == 1'b0) row[r] = 1'b0;
  end

  function automatic int code_of(input int i);
    case (i)
      0: return 1;  1: return 2;  2: return 3;
      3: return 4;  4: return 5;  5: return 6;
      6: return 7;  7: return 8;  8: return 9;
      9: return 11; 10: return 0; default: return 12;
    endcase
  endfunction

  function automatic bit counts(input int code);
`ifdef KEYPAD_SYMBOL_EN
    return code != 10;
`else
    return code <= 9;
`endif
  endfunction

  // 10 = nothing, 15 = more than one key, otherwise the single key's code.
  function automatic int scan_result(input logic [11:0] s);
    int cnt = 0;
    int code = 10;
    for (int i = 0; i < 12; i++)
      if (s[i] && counts(code_of(i))) begin
        cnt++;
        code = code_of(i);
      end
    if (cnt == 0) return 10;
    if (cnt > 1) return 15;
    return code;
  endfunction

  // One clock edge; advance the reference from the scan-level rules:
  // accept a key after DS identical single-key scans while nothing is held,
  // release after DS consecutive empty scans while a key is held.
  task automatic tick();
    int r;
    @(posedge clock);
    #1;
    if (!reset) begin
      n = 0; held = 10; run_val = 10; run_len = 0; exp_strobe = 1'b0;
    end else begin
      n++;
      exp_strobe = 1'b0;
      if (n % SCANP == 0) begin
        r = scan_result(pset);
        if (r == run_val) begin
          if (run_len < DS) run_len++;
        end else begin
          run_val = r;
          run_len = 1;
        end
        if (held == 10) begin
          if (r != 10 && r != 15 && run_len >= DS) begin
            held = r;
            exp_strobe = 1'b1;
          end
        end else if (r == 10 && run_len >= DS) begin
          held = 10;
        end
      end
    end
    case ((n / SD) % 3)
      0: exp_col = 3'b110;
      1: exp_col = 3'b101;
      default: exp_col = 3'b011;
    endcase
  endtask

  task automatic tick_to(input int t);
    while (n < t) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b1;
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic logic [11:0] rand_set();
    int p = $urandom_range(99);
    logic [11:0] s = '0;
    if (p < 40) return s;
    s[$urandom_range(11)] = 1'b1;
    if (p >= 85) s[$urandom_range(11)] = 1'b1;
    return s;
  endfunction

  // Every-cycle comparison against the reference.
  always @(negedge clock) begin
    if (chk_en) begin
      checks++;
      if (col !== exp_col) begin
        errors++;
        $display("FAIL col n=%0d got %b want %b", n, col, exp_col);
      end
      checks++;
      if (key !== 4'(held)) begin
        errors++;
        $display("FAIL key n=%0d got %0d want %0d", n, key, held);
      end
      checks++;
      if (key_strobe !== exp_strobe) begin
        errors++;
        $display("FAIL strobe n=%0d got %b want %b", n, key_strobe, exp_strobe);
      end
    end
  end

  initial begin
    // 1: reset state and column rotation
    do_reset();
    lit("reset_col", int'(col), 6);
    lit("reset_key", int'(key), 10);
    lit("reset_strobe", int'(key_strobe), 0);
    tick_to(4);
    lit("col_after4", int'(col), 5);
    tick_to(8);
    lit("col_after8", int'(col), 3);
    tick_to(12);
    lit("col_after12", int'(col), 6);

    // 2: '5' held, accepted on 3rd scan end, released after 3 quiet scans
    do_reset();
    pset = 12'b1 << 4;
    tick_to(35);
    lit("k5_before", int'(key), 10);
    tick();
    lit("k5_accept_key", int'(key), 5);
    lit("k5_accept_strobe", int'(key_strobe), 1);
    tick();
    lit("k5_strobe_1clk", int'(key_strobe), 0);
    tick_to(84);
    pset = '0;
    tick_to(119);
    lit("k5_held", int'(key), 5);
    tick();
    lit("k5_released", int'(key), 10);
    tick_to(156);

    // 3: one-scan bounce on '8'
    do_reset();
    pset = 12'b1 << 7;
    tick_to(12);
    pset = '0;
    tick_to(60);
    lit("bounce_key", int'(key), 10);

    // 4: '1' and '9' together
    do_reset();
    pset = (12'b1 << 0) | (12'b1 << 8);
    tick_to(60);
    lit("multi_key", int'(key), 10);
    pset = '0;
    tick_to(72);

    // 5: rollover blocking
    do_reset();
    pset = 12'b1 << 1;
    tick_to(36);
    lit("roll_k2", int'(key), 2);
    tick_to(60);
    pset = (12'b1 << 1) | (12'b1 << 2);
    tick_to(96);
    lit("roll_k2_kept", int'(key), 2);
    pset = '0;
    tick_to(131);
    lit("roll_k2_quiet", int'(key), 2);
    tick();
    lit("roll_released", int'(key), 10);
    pset = 12'b1 << 2;
    tick_to(168);
    lit("roll_k3_key", int'(key), 3);
    lit("roll_k3_strobe", int'(key_strobe), 1);

    // 6: reset mid-press, then symbol key
    do_reset();
    pset = 12'b1 << 10;
    tick_to(41);
    lit("k0_pressed", int'(key), 0);
    reset = 1'b0;
    tick();
    lit("k0_reset_key", int'(key), 10);
    reset = 1'b1;
    tick_to(35);
    lit("k0_rede_wait", int'(key), 10);
    tick();
    lit("k0_rede_key", int'(key), 0);
    lit("k0_rede_strobe", int'(key_strobe), 1);
    pset = '0;
    tick_to(72);
    lit("k0_release", int'(key), 10);
    pset = 12'b1 << 11;
    tick_to(108);
`ifdef KEYPAD_SYMBOL_EN
    lit("hash_key", int'(key), 12);
`else
    lit("hash_key", int'(key), 10);
`endif
    pset = '0;
    tick_to(156);

    // Randomised traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3600; i++) begin
      if (n % SCANP == 0 && $urandom_range(99) < 45) pset = rand_set();
      if ($urandom_range(999) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
